// File: rtl/control_conditioner.sv
// Purpose : Button/random front end for both fighters. It synchronises the raw
//           inputs, debounces the buttons, muxes the player-2 source, resolves
//           left+right conflicts and gates the controls on the play state.
// Latency : button edge to output is DEBOUNCE+3 frames; rnd/sel_random to
//           output is 3 frames; game_state to output is 1 frame.
// Backpr. : none. The outputs are level controls that are updated every frame.
//
// Optional feature macro: CTRL_ATTACK_PULSE_EN. When it is defined, pX_attack
// is a one-frame pulse on the rising edge of attack while the game is in play.
// When it is not defined, pX_attack follows the gated attack level.
//
// Ports:
//   clk             frame clock; all state updates on its rising edge
//   rst             asynchronous active-high reset
//   key_n[2:0]      player 1 raw buttons, active-low {left,right,attack}
//   gpio_n[2:0]     player 2 raw buttons, active-low {left,right,attack}
//   rnd[3:0]        free-running random bits, asynchronous
//   sel_random      1 = player 2 is driven from rnd; asynchronous
//   game_state[2:0] current game state, synchronous to clk
//   p1_*/p2_*       registered active-high controls for the two players

module control_conditioner #(
    parameter int          DEBOUNCE   = 2,
    parameter logic [2:0]  PLAY_STATE = 3'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    input  logic [2:0] gpio_n,
    input  logic [3:0] rnd,
    input  logic       sel_random,
    input  logic [2:0] game_state,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p1_attack,
    output logic       p2_left,
    output logic       p2_right,
    output logic       p2_attack
);

    // Terminal count of the debounce counter. A level must differ from the
    // accepted level for DEBOUNCE consecutive frames before it is taken.
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Button flops reset to "released" (1) so that
    // no press appears to come out of reset.
    // ------------------------------------------------------------------
    logic [2:0] key_s1, key_s2;
    logic [2:0] gpio_s1, gpio_s2;
    logic [3:0] rnd_s1, rnd_s2;
    logic       sel_s1, sel_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1  <= 3'b111;
            key_s2  <= 3'b111;
            gpio_s1 <= 3'b111;
            gpio_s2 <= 3'b111;
            rnd_s1  <= 4'd0;
            rnd_s2  <= 4'd0;
            sel_s1  <= 1'b0;
            sel_s2  <= 1'b0;
        end else begin
            key_s1  <= key_n;
            key_s2  <= key_s1;
            gpio_s1 <= gpio_n;
            gpio_s2 <= gpio_s1;
            rnd_s1  <= rnd;
            rnd_s2  <= rnd_s1;
            sel_s1  <= sel_random;
            sel_s2  <= sel_s1;
        end
    end

    // Invert after synchronisation so that 1 = pressed.
    // Channel map: [5:3] = player 1 {left,right,attack}, [2:0] = player 2.
    logic [5:0] btn_sync;
    assign btn_sync = {~key_s2, ~gpio_s2};

    // ------------------------------------------------------------------
    // Debouncers, one per button channel.
    // ------------------------------------------------------------------
    logic [5:0] btn_stable;

    genvar ch;
    generate
        for (ch = 0; ch < 6; ch++) begin : g_deb
            logic [3:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    btn_stable[ch] <= 1'b0;
                    cnt            <= 4'd0;
                end else if (btn_sync[ch] == btn_stable[ch]) begin
                    cnt <= 4'd0;
                end else if (cnt == CNT_LAST) begin
                    btn_stable[ch] <= btn_sync[ch];
                    cnt            <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-player levels before conflict resolution and gating.
    // ------------------------------------------------------------------
    logic p1_l, p1_r, p1_a;
    logic p2_l, p2_r, p2_a;

    assign p1_l = btn_stable[5];
    assign p1_r = btn_stable[4];
    assign p1_a = btn_stable[3];

    // The random source bypasses the debouncers. Their state keeps running,
    // so switching back shows the current debounced gpio levels at once.
    always_comb begin
        p2_l = btn_stable[2];
        p2_r = btn_stable[1];
        p2_a = btn_stable[0];
        if (sel_s2) begin
            p2_l = rnd_s2[0];
            p2_r = rnd_s2[1];
            p2_a = rnd_s2[2] & rnd_s2[3];
        end
    end

    logic in_play;
    assign in_play = (game_state == PLAY_STATE);

    // ------------------------------------------------------------------
    // Attack edge detector. It tracks the post-mux level every frame,
    // including while gated, so that a press made outside play is already
    // "old" when play begins.
    // ------------------------------------------------------------------
    logic [1:0] att_prev;   // [1] = player 1, [0] = player 2

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            att_prev <= 2'b00;
        end else begin
            att_prev <= {p1_a, p2_a};
        end
    end

    logic p1_rise, p2_rise;
    assign p1_rise = p1_a & ~att_prev[1];
    assign p2_rise = p2_a & ~att_prev[0];

    logic p1_att_nxt, p2_att_nxt;
`ifdef CTRL_ATTACK_PULSE_EN
    assign p1_att_nxt = in_play & p1_rise;
    assign p2_att_nxt = in_play & p2_rise;
`else
    // Level mode. A rising edge is always a subset of the level, so OR-ing
    // it in leaves the level unchanged. It keeps the detector connected.
    assign p1_att_nxt = in_play & (p1_a | p1_rise);
    assign p2_att_nxt = in_play & (p2_a | p2_rise);
`endif

    // ------------------------------------------------------------------
    // Output registers. Left+right together cancel out to no movement.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_left   <= 1'b0;
            p1_right  <= 1'b0;
            p1_attack <= 1'b0;
            p2_left   <= 1'b0;
            p2_right  <= 1'b0;
            p2_attack <= 1'b0;
        end else begin
            p1_left   <= in_play & p1_l & ~p1_r;
            p1_right  <= in_play & p1_r & ~p1_l;
            p1_attack <= p1_att_nxt;
            p2_left   <= in_play & p2_l & ~p2_r;
            p2_right  <= in_play & p2_r & ~p2_l;
            p2_attack <= p2_att_nxt;
        end
    end

endmodule

// File: tb/tb_control_conditioner.sv
module tb_control_conditioner;

`ifdef CTRL_ATTACK_PULSE_EN
    localparam bit PULSE = 1'b1;
`else
    localparam bit PULSE = 1'b0;
`endif
    localparam logic ATT_LVL = ~PULSE;   // steady-state attack output when held

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_n = 3'b111;
    logic [2:0] gpio_n = 3'b111;
    logic [3:0] rnd = 4'd0;
    logic       sel_random = 1'b0;
    logic [2:0] game_state = 3'd2;
    logic       p1_left, p1_right, p1_attack, p2_left, p2_right, p2_attack;
    logic [5:0] outs;

    assign outs = {p1_left, p1_right, p1_attack, p2_left, p2_right, p2_attack};

    always #5 clk = ~clk;

    control_conditioner dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .gpio_n     (gpio_n),
        .rnd        (rnd),
        .sel_random (sel_random),
        .game_state (game_state),
        .p1_left    (p1_left),
        .p1_right   (p1_right),
        .p1_attack  (p1_attack),
        .p2_left    (p2_left),
        .p2_right   (p2_right),
        .p2_attack  (p2_attack)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Advance one frame. Outputs are sampled 1 ns after the rising edge, and
    // new inputs are applied after that sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle();
        key_n = 3'b111; gpio_n = 3'b111; sel_random = 1'b0; rnd = 4'd0;
        game_state = 3'd2;
        steps(8);
    endtask

    typedef struct {
        logic [2:0] key_n;
        logic [2:0] gpio_n;
        logic [3:0] rnd;
        logic       sel;
        logic [2:0] gs;
        logic [5:0] exp;   // {p1 l,r,a, p2 l,r,a} after 6 frames
    } vec_t;

    vec_t tbl[11];
    int   cnt, cnt2;

    initial begin
        // Each row is held for 6 frames, which covers the 5-frame button latency.
        tbl[0]  = '{3'b111, 3'b111, 4'b0000, 1'b0, 3'd2, 6'b000000};
        tbl[1]  = '{3'b011, 3'b111, 4'b0000, 1'b0, 3'd2, 6'b100000};
        tbl[2]  = '{3'b101, 3'b111, 4'b0000, 1'b0, 3'd2, 6'b010000};
        tbl[3]  = '{3'b001, 3'b111, 4'b0000, 1'b0, 3'd2, 6'b000000};
        tbl[4]  = '{3'b110, 3'b111, 4'b0000, 1'b0, 3'd2, {2'b00, ATT_LVL, 3'b000}};
        tbl[5]  = '{3'b111, 3'b010, 4'b0000, 1'b0, 3'd2, {5'b00010, ATT_LVL}};
        tbl[6]  = '{3'b111, 3'b101, 4'b1101, 1'b1, 3'd2, {5'b00010, ATT_LVL}};
        tbl[7]  = '{3'b111, 3'b101, 4'b0011, 1'b1, 3'd2, 6'b000000};
        tbl[8]  = '{3'b111, 3'b101, 4'b1110, 1'b1, 3'd2, {5'b00001, ATT_LVL}};
        tbl[9]  = '{3'b111, 3'b101, 4'b1110, 1'b1, 3'd1, 6'b000000};
        tbl[10] = '{3'b101, 3'b101, 4'b0000, 1'b0, 3'd2, 6'b010010};

        // Hold reset for a few frames, then check the reset state.
        steps(3);
        check("reset_outs", outs, 6'b0);
        rst = 1'b0;

        // Table-driven steady-state vectors.
        for (int v = 0; v < 11; v++) begin
            key_n = tbl[v].key_n; gpio_n = tbl[v].gpio_n; rnd = tbl[v].rnd;
            sel_random = tbl[v].sel; game_state = tbl[v].gs;
            steps(6);
            check($sformatf("vec%0d", v), outs, tbl[v].exp);
        end

        // Asynchronous reset mid-frame with all p1 buttons held.
        idle();
        key_n = 3'b000;
        steps(7);
        #2 rst = 1'b1;
        #1 check("rst_async", outs, 6'b0);
        step();
        rst = 1'b0;
        steps(4);
        check("rst_edge4_att", p1_attack, 1'b0);
        step();
        check("rst_edge5_att", p1_attack, 1'b1);
        check("rst_edge5_lr", {p1_left, p1_right}, 2'b00);

        // A one-frame glitch on left must never be accepted.
        idle();
        key_n = 3'b011;
        step();
        key_n = 3'b111;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (p1_left) cnt++;
        end
        check("glitch_left", cnt, 0);

        // A 3-frame press: left is high on edges 5..7 after the fall and
        // drops 5 edges after the rise (edge 8).
        key_n = 3'b011;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) key_n = 3'b111;
            if (i >= 3 && i <= 9)
                check($sformatf("press_e%0d", i), p1_left, (i >= 5 && i < 8));
        end

        // Random source: 3-frame latency, and gpio has no effect.
        idle();
        sel_random = 1'b1; rnd = 4'b1101;
        steps(2);
        check("rnd_e2", {p2_left, p2_right, p2_attack}, 3'b000);
        step();
        check("rnd_e3", {p2_left, p2_right, p2_attack}, 3'b101);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            gpio_n = gpio_n ^ 3'b111;
            step();
            if ({p2_left, p2_right} != 2'b10 || p2_attack != ATT_LVL) cnt++;
        end
        check("rnd_gpio_ignored", cnt, 0);

        // Gating: leave play and re-enter with left held.
        idle();
        key_n = 3'b011;
        steps(6);
        check("gate_pre", p1_left, 1'b1);
        game_state = 3'd1;
        step();
        check("gate_off", p1_left, 1'b0);
        steps(3);
        check("gate_hold", p1_left, 1'b0);
        game_state = 3'd2;
        step();
        check("gate_on", p1_left, 1'b1);

        // An attack pressed while gated must not pulse on entering play.
        idle();
        game_state = 3'd1;
        key_n = 3'b110;
        steps(7);
        game_state = 3'd2;
        step();
        check("gated_att_enter", p1_attack, ATT_LVL);

        // Hold p2 attack for 20 frames, then release.
        idle();
        gpio_n = 3'b110;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (p2_attack) cnt++;
        end
        gpio_n = 3'b111;
        cnt2 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (p2_attack) cnt2++;
        end
        check("att_hold_window", cnt, PULSE ? 1 : 16);
        check("att_after_release", cnt2, PULSE ? 0 : 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_conditioner.md
# control_conditioner

Front-end input stage for both fighters. It takes the raw active-low push-button lines (KEY for player 1, GPIO for player 2) and the free-running random-number bits, and synchronises them into the frame clock domain. It debounces the physical buttons, resolves conflicting left/right requests, and gates everything on the game being in the play state. Its six registered outputs drive the `left`/`right`/`attack` inputs of the two `player` instances directly.

## Interface
Parameters:
- `DEBOUNCE`, default 2: frames a synchronised button level must differ from the debounced level before it is accepted. Legal range 1..15.
- `PLAY_STATE`, default 3'd2: `game_state` value in which controls are live.

Ports:
- `clk` in 1: frame clock (`effective_clk`). All state is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `key_n` in 3: player 1 raw buttons, active-low. [2]=left, [1]=right, [0]=attack.
- `gpio_n` in 3: player 2 raw buttons, active-low. [2]=left, [1]=right, [0]=attack.
- `rnd` in 4: random bits from `random_num`, asynchronous to `clk`.
- `sel_random` in 1: 1 selects the random source for player 2 (SW[0]). Asynchronous.
- `game_state` in 3: current game state, synchronous to `clk`.
- `p1_left`, `p1_right`, `p1_attack` out 1 each: player 1 controls, active-high, registered.
- `p2_left`, `p2_right`, `p2_attack` out 1 each: player 2 controls, active-high, registered.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each of `key_n`, `gpio_n`, `rnd` and `sel_random`.
  - `key_n`/`gpio_n` flops reset to 1 (released).
  - `rnd`/`sel_random` flops reset to 0.
  - Button levels are inverted after synchronisation, so 1 = pressed.
- **Debouncer, per button channel (6 channels):**
  - Holds a `stable` bit (reset 0) and a counter (reset 0, 4 bits).
  - If sync == `stable`, the counter clears.
  - If sync != `stable` and counter == DEBOUNCE-1: `stable` <= sync and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE frames never changes `stable`.
- **Player 2 source:**
  - `sel_random`=0: the debounced `gpio` channels.
  - `sel_random`=1: left=rnd[0], right=rnd[1], attack=rnd[2]&rnd[3]. These come from the synchronised `rnd` bits, not debounced.
  - Switching source takes effect on the next output update. No debouncer state is cleared.
- **Conflict rule:** if left and right are both 1 for a player, both outputs are 0. Attack is unaffected.
- **Gating:**
  - If `game_state` != PLAY_STATE, all six outputs register 0.
  - The debouncers and the attack edge detector keep running while gated.
- **Attack edge detector:**
  - Keeps `att_prev` per player (reset 0), updated every cycle with the post-mux attack level, regardless of gating.
  - Consumed only when ATTACK_PULSE_EN is defined.

## Timing
- Reset: all outputs 0 immediately, asynchronously. All internal state returns to its reset value. Reset mid-debounce discards the partial count.
- **Button latency (raw edge to output edge):** DEBOUNCE+3 cycles.
  - Sync: edges 1–2.
  - `stable` flips at edge 2+DEBOUNCE.
  - Output registers at edge 3+DEBOUNCE.
  - With the default, 5 frames.
- **Random path latency:** 3 cycles. `sel_random` latency is also 3 cycles.
- **Gating latency:**
  - A `game_state` change affects outputs at the next edge (1 cycle).
  - Entering PLAY_STATE with a button already debounced-pressed: the level outputs are 1 at the first edge in play.
- **Release:** same latency as press, DEBOUNCE+3.

## Configuration
- `CTRL_ATTACK_PULSE_EN` defined:
  - `pX_attack` is a 1-cycle pulse when attack is 1 and `att_prev` is 0 and the block is in play.
  - Holding the button gives exactly one pulse.
  - A press that rose while gated does not fire on entering play.
- Not defined: `pX_attack` follows the gated attack level. The edge detector is still built but unused.

## Test plan
1. Assert `rst` mid-frame with `key_n`=3'b000 held -> all outputs 0 at once. After release with `game_state`=2, `p1_left`=`p1_right`=0 (conflict) and `p1_attack`=1 at edge 5.
2. `game_state`=2, `key_n[2]` low for 1 frame then high -> `p1_left` never asserts. Low for 2+ frames -> `p1_left`=1 exactly 5 edges after the fall, and 0 five edges after the rise.
3. `sel_random`=1, `rnd`=4'b1101 -> `p2_left`=1, `p2_right`=0, `p2_attack`=1 after 3 edges. With `gpio_n` toggling, `gpio_n` has no effect.
4. Buttons held pressed, `game_state` toggles 2->1->2 -> outputs drop to 0 one edge after leaving 2, and return one edge after re-entering.
5. `CTRL_ATTACK_PULSE_EN` defined, `gpio_n[0]` held low 20 frames in play -> `p2_attack` high for exactly 1 cycle. Macro undefined -> high for 16 cycles (20 frames minus the 4-frame sync/debounce delay, before the button is released).
